emc_xmem_ctrl: RTL and testbench
================================

# emc_xmem_ctrl

External memory bus controller for the EMC08. Arbitrates between the CPU instruction-fetch port and the MOVX data port. Sequences each access onto the external 64K×8 SPRAM bus:
- P2 carries the high address, P4 the low address.
- P0 carries data (P0 output for write data, P0 input for read data).
- PSEN_B drives RAM ENB; P3.6 drives WEB; P3.7 drives OEB.

The block sits between the core and the pad ring.

## Interface
Parameters:
- ADDR_W, 16, external address width (P2:P4)
- DATA_W, 8, data width (P0)

Ports (clock and reset first):
- xmc_clock_i  in  1  system clock; one clock, all logic on rising edge
- xmc_reset_i  in  1  synchronous, active-high reset
- xmc_if_req_i  in  1  fetch request; held high until ack
- xmc_if_addr_i  in  16  fetch address; stable while req high
- xmc_if_ack_o  out  1  one-cycle fetch completion pulse
- xmc_if_data_o  out  8  fetched byte; valid with ack, held until the next fetch ack
- xmc_d_req_i  in  1  data request; held high until ack
- xmc_d_we_i  in  1  1 = write, 0 = read
- xmc_d_addr_i  in  16  data address
- xmc_d_wdata_i  in  8  write data
- xmc_d_ack_o  out  1  one-cycle data completion pulse
- xmc_d_rdata_o  out  8  read byte; valid with ack, held until the next data-read ack
- xmc_wait_i  in  2  wait states W (0–3), sampled at grant
- xmc_p0_y_i  in  8  P0 pad input (RAM Q)
- xmc_p0_a_o  out  8  P0 pad output (write data)
- xmc_p0_en_o  out  8  P0 pad output enable; 8'hFF = drive
- xmc_p2_a_o  out  8  address[15:8]
- xmc_p4_a_o  out  8  address[7:0]
- xmc_psen_b_o  out  1  RAM enable, active low
- xmc_wr_b_o  out  1  write strobe (P3.6), active low
- xmc_rd_b_o  out  1  read/output strobe (P3.7), active low
- xmc_busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- IDLE
  - Sample both reqs.
  - On grant, latch the winner's address, we, wdata (data port only) and W; wait counter := W.
  - Next state SETUP.
  - With no req, stay in IDLE.
- SETUP (1 cycle)
  - Address is on P2/P4 and psen_b = 0; rd_b and wr_b stay 1.
  - Write: p0_a = wdata, p0_en = FF.
  - Read: p0_en = 00.
- STROBE (1+W cycles)
  - Read: rd_b = 0. Write: wr_b = 0.
  - Counter decrements each cycle; leave when the counter is 0.
  - Read: p0_y_i is captured into the port's data register on the edge leaving STROBE.
- HOLD (1 cycle)
  - Strobes return to 1; psen_b stays 0; address is held.
  - Write data and p0_en = FF are held for data hold time.
  - The granted port's ack pulses high. Next state IDLE.
- Leaving HOLD: psen_b = 1, p0_en = 00. P2/P4 keep the last address (no toggling).
- Instruction fetches are always reads; xmc_if port has no write path.
- Arbitration: round-robin on a last-owner flag.
  - Both requesting: the port not served last wins.
  - Single requester: always granted.
  - Reset sets last-owner = data, so fetch wins first.
- Requester rule: deassert req in the cycle after ack. A req still high in IDLE is a new request.
- If req drops mid-access, the access still completes and ack still pulses.
- xmc_wait_i changes after grant have no effect on the current access.

## Timing
- Reset values (next edge with xmc_reset_i = 1, from any state):
  - psen_b = wr_b = rd_b = 1.
  - p0_en = 00; p0_a = p2 = p4 = 00.
  - Both acks = 0; if_data = d_rdata = 00; busy = 0.
  - FSM = IDLE; last-owner = data.
- Reset mid-access: strobes are released immediately, no ack is issued, and the access is discarded.
- Latency: a req high in IDLE cycle t0 produces ack in cycle t0 + 3 + W.
- Back-to-back throughput: one access per 4 + W cycles (includes the IDLE cycle).
- Strobe width: exactly 1 + W cycles.
- Address and psen_b are asserted one full cycle before the strobe and held one cycle after it.

## Test plan
- Reset: hold reset for 2 cycles during a write STROBE → next edge psen_b/wr_b/rd_b = 1, p0_en = 00, p2/p4 = 00, no ack, busy = 0.
- Fetch read, RAM[1234] = A5, W = 0: req at t0 → t1 p2 = 12, p4 = 34, psen_b = 0 → t2 rd_b = 0 for 1 cycle → t3 if_ack = 1, if_data = A5.
- Data write 8001 ← 3C, W = 2:
  - wr_b = 0 for 3 cycles.
  - p0_a = 3C and p0_en = FF from SETUP through HOLD.
  - d_ack at t5.
  - A following data read of 8001 returns 3C.
- Both reqs held continuously after reset, W = 0: grant order F, D, F, D; each ack 4 cycles apart; no strobe overlap.
- Change xmc_wait_i from 0 to 3 during STROBE of a W = 0 read → strobe stays 1 cycle; the next access uses W = 3 (4-cycle strobe).
- Data req dropped in SETUP → access completes, d_ack pulses once, FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/emc_xmem_ctrl.sv
// EMC08 external SPRAM bus sequencer: round-robin fetch/MOVX arbitration, registered bus outputs.
// States: IDLE arbitrate | SETUP address+psen | STROBE rd/wr low 1+W cycles | HOLD ack, data hold
module emc_xmem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              xmc_clock_i,
    input  logic              xmc_reset_i,
    input  logic              xmc_if_req_i,
    input  logic [ADDR_W-1:0] xmc_if_addr_i,
    output logic              xmc_if_ack_o,
    output logic [DATA_W-1:0] xmc_if_data_o,
    input  logic              xmc_d_req_i,
    input  logic              xmc_d_we_i,
    input  logic [ADDR_W-1:0] xmc_d_addr_i,
    input  logic [DATA_W-1:0] xmc_d_wdata_i,
    output logic              xmc_d_ack_o,
    output logic [DATA_W-1:0] xmc_d_rdata_o,
    input  logic [1:0]        xmc_wait_i,
    input  logic [DATA_W-1:0] xmc_p0_y_i,
    output logic [DATA_W-1:0] xmc_p0_a_o,
    output logic [DATA_W-1:0] xmc_p0_en_o,
    output logic [7:0]        xmc_p2_a_o,
    output logic [7:0]        xmc_p4_a_o,
    output logic              xmc_psen_b_o,
    output logic              xmc_wr_b_o,
    output logic              xmc_rd_b_o,
    output logic              xmc_busy_o
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t state_q, state_nxt;
    logic [1:0] cnt_q, cnt_nxt;
    logic we_q, we_nxt;
    logic sel_d_q, sel_d_nxt;
    logic owner_d_q, owner_d_nxt;

    logic              grant_if, grant_d, g_we;
    logic [ADDR_W-1:0] g_addr;

    logic [DATA_W-1:0] p0_a_nxt, p0_en_nxt, if_data_nxt, d_rdata_nxt;
    logic [7:0]        p2_nxt, p4_nxt;
    logic              psen_b_nxt, wr_b_nxt, rd_b_nxt;
    logic              if_ack_nxt, d_ack_nxt, busy_nxt;

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        we_nxt      = we_q;
        sel_d_nxt   = sel_d_q;
        owner_d_nxt = owner_d_q;
        p0_a_nxt    = xmc_p0_a_o;
        p0_en_nxt   = xmc_p0_en_o;
        p2_nxt      = xmc_p2_a_o;
        p4_nxt      = xmc_p4_a_o;
        psen_b_nxt  = xmc_psen_b_o;
        wr_b_nxt    = xmc_wr_b_o;
        rd_b_nxt    = xmc_rd_b_o;
        if_ack_nxt  = 1'b0;
        d_ack_nxt   = 1'b0;
        if_data_nxt = xmc_if_data_o;
        d_rdata_nxt = xmc_d_rdata_o;
        busy_nxt    = xmc_busy_o;

        // owner_d_q = 1 means the data port was served last, so fetch has priority
        grant_if = xmc_if_req_i && (!xmc_d_req_i || owner_d_q);
        grant_d  = xmc_d_req_i && !grant_if;
        g_addr   = grant_if ? xmc_if_addr_i : xmc_d_addr_i;
        g_we     = grant_d && xmc_d_we_i;

        case (state_q)
            IDLE: begin
                if (grant_if || grant_d) begin
                    state_nxt   = SETUP;
                    cnt_nxt     = xmc_wait_i;
                    we_nxt      = g_we;
                    sel_d_nxt   = grant_d;
                    owner_d_nxt = grant_d;
                    p2_nxt      = g_addr[ADDR_W-1 -: 8];
                    p4_nxt      = g_addr[7:0];
                    psen_b_nxt  = 1'b0;
                    busy_nxt    = 1'b1;
                    if (g_we) begin
                        p0_a_nxt  = xmc_d_wdata_i;
                        p0_en_nxt = '1;
                    end else begin
                        p0_en_nxt = '0;
                    end
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                rd_b_nxt  = we_q;
                wr_b_nxt  = !we_q;
            end
            STROBE: begin
                if (cnt_q == 2'd0) begin
                    state_nxt = HOLD;
                    rd_b_nxt  = 1'b1;
                    wr_b_nxt  = 1'b1;
                    if (sel_d_q) begin
                        d_ack_nxt = 1'b1;
                        if (!we_q) d_rdata_nxt = xmc_p0_y_i;
                    end else begin
                        if_ack_nxt  = 1'b1;
                        if_data_nxt = xmc_p0_y_i;
                    end
                end else begin
                    cnt_nxt = cnt_q - 2'd1;
                end
            end
            HOLD: begin
                state_nxt  = IDLE;
                psen_b_nxt = 1'b1;
                p0_en_nxt  = '0;
                busy_nxt   = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge xmc_clock_i) begin
        if (xmc_reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            we_q          <= 1'b0;
            sel_d_q       <= 1'b0;
            owner_d_q     <= 1'b1;
            xmc_p0_a_o    <= '0;
            xmc_p0_en_o   <= '0;
            xmc_p2_a_o    <= 8'h00;
            xmc_p4_a_o    <= 8'h00;
            xmc_psen_b_o  <= 1'b1;
            xmc_wr_b_o    <= 1'b1;
            xmc_rd_b_o    <= 1'b1;
            xmc_if_ack_o  <= 1'b0;
            xmc_d_ack_o   <= 1'b0;
            xmc_if_data_o <= '0;
            xmc_d_rdata_o <= '0;
            xmc_busy_o    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            we_q          <= we_nxt;
            sel_d_q       <= sel_d_nxt;
            owner_d_q     <= owner_d_nxt;
            xmc_p0_a_o    <= p0_a_nxt;
            xmc_p0_en_o   <= p0_en_nxt;
            xmc_p2_a_o    <= p2_nxt;
            xmc_p4_a_o    <= p4_nxt;
            xmc_psen_b_o  <= psen_b_nxt;
            xmc_wr_b_o    <= wr_b_nxt;
            xmc_rd_b_o    <= rd_b_nxt;
            xmc_if_ack_o  <= if_ack_nxt;
            xmc_d_ack_o   <= d_ack_nxt;
            xmc_if_data_o <= if_data_nxt;
            xmc_d_rdata_o <= d_rdata_nxt;
            xmc_busy_o    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_emc_xmem_ctrl.sv
// Bench for emc_xmem_ctrl: SPRAM model on the pads, expected results queued at request time.
module tb_emc_xmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, d_req, d_we, d_ack;
    logic [15:0] if_addr, d_addr;
    logic [7:0]  if_data, d_wdata, d_rdata;
    logic [1:0]  wait_st;
    logic [7:0]  p0_y, p0_a, p0_en, p2, p4;
    logic        psen_b, wr_b, rd_b, busy;

    always #5 clk = ~clk;

    emc_xmem_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .xmc_clock_i   (clk),
        .xmc_reset_i   (reset),
        .xmc_if_req_i  (if_req),
        .xmc_if_addr_i (if_addr),
        .xmc_if_ack_o  (if_ack),
        .xmc_if_data_o (if_data),
        .xmc_d_req_i   (d_req),
        .xmc_d_we_i    (d_we),
        .xmc_d_addr_i  (d_addr),
        .xmc_d_wdata_i (d_wdata),
        .xmc_d_ack_o   (d_ack),
        .xmc_d_rdata_o (d_rdata),
        .xmc_wait_i    (wait_st),
        .xmc_p0_y_i    (p0_y),
        .xmc_p0_a_o    (p0_a),
        .xmc_p0_en_o   (p0_en),
        .xmc_p2_a_o    (p2),
        .xmc_p4_a_o    (p4),
        .xmc_psen_b_o  (psen_b),
        .xmc_wr_b_o    (wr_b),
        .xmc_rd_b_o    (rd_b),
        .xmc_busy_o    (busy)
    );

    // SPRAM: Q visible only while enabled and output-enabled; writes on clock while WEB low
    logic [7:0]  ram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;

    assign p0_y = (!psen_b && !rd_b) ? ram[{p2, p4}] : 8'hEE;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (!reset && !psen_b && !wr_b && p0_en == 8'hFF) ram[{p2, p4}] <= p0_a;
    end

    logic [7:0] model [0:65535];

    typedef struct {
        bit         port_d;
        bit         is_wr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        model[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int cyc, output bit port_d);
        cyc    = -1;
        port_d = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                cyc    = i;
                port_d = d_ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({psen_b, wr_b, rd_b, busy, if_ack, d_ack} !== 6'b111000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 111000", {psen_b, wr_b, rd_b, busy, if_ack, d_ack});
        end
        n_checks++;
        if ({p0_en, p0_a, p2, p4, if_data, d_rdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h required 0", {p0_en, p0_a, p2, p4, if_data, d_rdata});
        end
        reset = 1'b0;

        wait_st = 2'd2;
        d_we    = 1'b1;
        d_addr  = 16'h4321;
        d_wdata = 8'h77;
        d_req   = 1'b1;
        seen    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!wr_b) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1) begin
            n_fail++;
            $display("FAIL reset_reach_strobe: got %0d required 1", seen);
        end
        reset = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({psen_b, wr_b, rd_b, p0_en, p2, p4, busy, d_ack, if_ack} !== {3'b111, 24'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid_access: got %b %h %h %h %b required 111 00 00 00 000",
                     {psen_b, wr_b, rd_b}, p0_en, p2, p4, {busy, d_ack, if_ack});
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d_ack || if_ack || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d ack/busy cycles required 0", seen);
        end
    endtask

    task automatic test_fetch_read();
        exp_t e;
        preload(16'h1234, 8'hA5);
        wait_st = 2'd0;
        if_addr = 16'h1234;
        if_req  = 1'b1;
        sb.push_back('{port_d: 1'b0, is_wr: 1'b0, data: model[16'h1234]});
        @(negedge clk);
        n_checks++;
        if ({p2, p4, psen_b, rd_b, wr_b} !== {16'h1234, 3'b011}) begin
            n_fail++;
            $display("FAIL fetch_setup: got %h%h %b required 1234 011", p2, p4, {psen_b, rd_b, wr_b});
        end
        @(negedge clk);
        n_checks++;
        if ({psen_b, rd_b, wr_b, if_ack} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fetch_strobe: got %b required 0010", {psen_b, rd_b, wr_b, if_ack});
        end
        @(negedge clk);
        n_checks++;
        if ({if_ack, d_ack, rd_b, psen_b, p2, p4} !== {4'b1010, 16'h1234}) begin
            n_fail++;
            $display("FAIL fetch_hold: got %b %h%h required 1010 1234", {if_ack, d_ack, rd_b, psen_b}, p2, p4);
        end
        e = sb.pop_front();
        n_checks++;
        if (if_data !== e.data) begin
            n_fail++;
            $display("FAIL fetch_data: got %h required %h", if_data, e.data);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_ack, psen_b, busy, p0_en, p2, p4, if_data} !== {3'b010, 8'h00, 16'h1234, e.data}) begin
            n_fail++;
            $display("FAIL fetch_release: got %b %h %h%h %h required 010 00 1234 %h",
                     {if_ack, psen_b, busy}, p0_en, p2, p4, if_data, e.data);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        int   wr_low, bad, cyc;
        bit   pd;
        wait_st = 2'd2;
        d_we    = 1'b1;
        d_addr  = 16'h8001;
        d_wdata = 8'h3C;
        d_req   = 1'b1;
        model[16'h8001] = 8'h3C;
        sb.push_back('{port_d: 1'b1, is_wr: 1'b1, data: 8'h3C});
        wr_low = 0;
        bad    = 0;
        cyc    = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!wr_b) wr_low++;
            if (!psen_b && (p0_a !== 8'h3C || p0_en !== 8'hFF)) bad++;
            if (!rd_b) bad++;
            if (d_ack) begin
                cyc = i;
                break;
            end
        end
        d_req = 1'b0;
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL write_ack_latency: got %0d required 5", cyc);
        end
        n_checks++;
        if (wr_low !== 3) begin
            n_fail++;
            $display("FAIL write_strobe_width: got %0d required 3", wr_low);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL write_data_drive: got %0d bad cycles required 0", bad);
        end
        e = sb.pop_front();
        n_checks++;
        if ({e.port_d, e.is_wr} !== {d_ack, 1'b1}) begin
            n_fail++;
            $display("FAIL write_port: got d_ack %b required 1", d_ack);
        end
        @(negedge clk);
        n_checks++;
        if ({p0_en, psen_b} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL write_release: got %h %b required 00 1", p0_en, psen_b);
        end
        wait_st = 2'd0;
        d_we    = 1'b0;
        d_req   = 1'b1;
        sb.push_back('{port_d: 1'b1, is_wr: 1'b0, data: model[16'h8001]});
        wait_ack(12, cyc, pd);
        d_req = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({cyc, pd} !== {32'd3, e.port_d}) begin
            n_fail++;
            $display("FAIL readback_ack: got cyc %0d port %b required 3 %b", cyc, pd, e.port_d);
        end
        n_checks++;
        if (d_rdata !== e.data) begin
            n_fail++;
            $display("FAIL readback_data: got %h required %h", d_rdata, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n, overlap, want;
        preload(16'h0010, 8'h11);
        preload(16'h0020, 8'h22);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        wait_st = 2'd0;
        if_addr = 16'h0010;
        d_addr  = 16'h0020;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{port_d: 1'b0, is_wr: 1'b0, data: model[16'h0010]});
            sb.push_back('{port_d: 1'b1, is_wr: 1'b0, data: model[16'h0020]});
        end
        n       = 0;
        overlap = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!rd_b && !wr_b) overlap++;
            if (if_ack || d_ack) begin
                want = 3 + 4 * n;
                n++;
                e = sb.pop_front();
                n_checks++;
                if ({if_ack, d_ack} !== {!e.port_d, e.port_d} || i !== want) begin
                    n_fail++;
                    $display("FAIL b2b_order_%0d: got acks %b at cycle %0d required %b at %0d",
                             n, {if_ack, d_ack}, i, {!e.port_d, e.port_d}, want);
                end
                n_checks++;
                if ((e.port_d ? d_rdata : if_data) !== e.data) begin
                    n_fail++;
                    $display("FAIL b2b_data_%0d: got %h required %h", n, e.port_d ? d_rdata : if_data, e.data);
                end
                if (n == 4) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                    break;
                end
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        n_checks++;
        if ({n, overlap} !== {32'd4, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d acks %0d overlaps required 4 0", n, overlap);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, psen_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b required 01", {busy, psen_b});
        end
        sb.delete();
    endtask

    task automatic test_wait_change();
        exp_t e;
        int   rd_low, cyc;
        preload(16'h00AB, 8'h5A);
        wait_st = 2'd0;
        if_addr = 16'h00AB;
        for (int pass = 0; pass < 2; pass++) begin
            if_req = 1'b1;
            sb.push_back('{port_d: 1'b0, is_wr: 1'b0, data: model[16'h00AB]});
            rd_low = 0;
            cyc    = -1;
            for (int i = 1; i <= 15; i++) begin
                @(negedge clk);
                if (!rd_b) begin
                    rd_low++;
                    wait_st = 2'd3;
                end
                if (if_ack) begin
                    cyc = i;
                    break;
                end
            end
            if_req = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({rd_low, cyc} !== (pass == 0 ? {32'd1, 32'd3} : {32'd4, 32'd6})) begin
                n_fail++;
                $display("FAIL wait_change_%0d: got strobe %0d ack %0d required %0d %0d",
                         pass, rd_low, cyc, pass == 0 ? 1 : 4, pass == 0 ? 3 : 6);
            end
            n_checks++;
            if (if_data !== e.data) begin
                n_fail++;
                $display("FAIL wait_change_data_%0d: got %h required %h", pass, if_data, e.data);
            end
            @(negedge clk);
        end
        wait_st = 2'd0;
    endtask

    task automatic test_req_drop();
        exp_t e;
        int   acks, ack_cyc;
        logic [7:0] got;
        preload(16'h0055, 8'hC3);
        wait_st = 2'd1;
        d_we    = 1'b0;
        d_addr  = 16'h0055;
        d_req   = 1'b1;
        sb.push_back('{port_d: 1'b1, is_wr: 1'b0, data: model[16'h0055]});
        @(negedge clk);
        n_checks++;
        if ({busy, psen_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_setup: got %b required 10", {busy, psen_b});
        end
        d_req   = 1'b0;
        acks    = 0;
        ack_cyc = -1;
        got     = 8'h00;
        for (int i = 2; i <= 14; i++) begin
            @(negedge clk);
            if (d_ack) begin
                acks++;
                ack_cyc = i;
                got     = d_rdata;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if ({acks, ack_cyc} !== {32'd1, 32'd4}) begin
            n_fail++;
            $display("FAIL drop_ack: got %0d acks at %0d required 1 at 4", acks, ack_cyc);
        end
        n_checks++;
        if (got !== e.data) begin
            n_fail++;
            $display("FAIL drop_data: got %h required %h", got, e.data);
        end
        n_checks++;
        if ({busy, psen_b, rd_b, wr_b} !== 4'b0111) begin
            n_fail++;
            $display("FAIL drop_idle: got %b required 0111", {busy, psen_b, rd_b, wr_b});
        end
    endtask

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 8'h0;
        wait_st = 2'd0;
        test_reset();
        test_fetch_read();
        test_write_read();
        test_back_to_back();
        test_wait_change();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
